// File: rtl/l2_responder_pkg.sv
// Types shared between the bus controller and the L2 responder.
package l2_responder_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] longWord_t;

  typedef enum logic [1:0] {
    L2_FREE   = 2'b00,
    L2_BUSY   = 2'b01,
    L2_ACCESS = 2'b10,
    L2_ERROR  = 2'b11
  } l2_state_t;

  typedef struct packed {
    logic      wr;
    word_t     addr;
    longWord_t store;
  } l2_req_t;

  // High word of a 64-bit access; wraps modulo 2^32.
  function automatic word_t hi_word_addr(input word_t a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/l2_timeout_ctr.sv
// Per-beat stall counter; expired pulses in the busy cycle that brings the
// count up to TIMEOUT, so the owner can leave the beat on that edge.
module l2_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic busy,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = busy && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/l2_responder.sv
// Serves a 64-bit L2 request as two little-endian 32-bit memory beats.
// Responds L2_ACCESS in cycle 3 with no stalls; malformed or stalled-out requests get L2_ERROR.
module l2_responder
  import l2_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       l2REN,
  input  logic       l2WEN,
  input  word_t      l2addr,
  input  longWord_t  l2store,
  output longWord_t  l2load,
  output l2_state_t  l2state,
  output logic       mem_ren,
  output logic       mem_wen,
  output word_t      mem_addr,
  output word_t      mem_wdata,
  input  word_t      mem_rdata,
  input  logic       mem_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BEAT0 = 3'd1;
  localparam logic [2:0] S_BEAT1 = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0] state_q, state_d;
  l2_req_t    req_q, req_d;
  word_t      lo_q, lo_d;
  longWord_t  load_q, load_d;

  logic in_beat, hi_beat, beat_done, ctr_busy, expired;

  assign in_beat   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
  assign hi_beat   = (state_q == S_BEAT1);
  assign beat_done = in_beat && !mem_busy;
  assign ctr_busy  = in_beat && mem_busy;

  // Any non-stalled cycle clears, so each beat starts counting from zero.
  l2_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (!ctr_busy),
    .busy    (ctr_busy),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    lo_d    = lo_q;
    load_d  = load_q;
    l2state = L2_FREE;
    case (state_q)
      S_IDLE: begin
        if (l2REN || l2WEN) begin
          req_d.wr    = l2WEN;
          req_d.addr  = l2addr;
          req_d.store = l2store;
          if ((l2REN && l2WEN) || (l2addr[2:0] != 3'b000)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_BEAT0;
          end
        end
      end
      S_BEAT0, S_BEAT1: begin
        l2state = L2_BUSY;
        if (expired) begin
          state_d = S_ERR;
        end else if (beat_done) begin
          // Low word is staged so l2load only changes on a complete read.
          if (!req_q.wr) begin
            if (hi_beat) begin
              load_d = {mem_rdata, lo_q};
            end else begin
              lo_d = mem_rdata;
            end
          end
          state_d = hi_beat ? S_RESP : S_BEAT1;
        end
      end
      S_RESP: begin
        l2state = L2_ACCESS;
        state_d = S_IDLE;
      end
      S_ERR: begin
        l2state = L2_ERROR;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_ren   = in_beat && !req_q.wr;
  assign mem_wen   = in_beat && req_q.wr;
  assign mem_addr  = !in_beat ? '0 : (hi_beat ? hi_word_addr(req_q.addr) : req_q.addr);
  assign mem_wdata = !in_beat ? '0 : (hi_beat ? req_q.store[63:32] : req_q.store[31:0]);
  assign l2load    = load_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      lo_q    <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      lo_q    <= lo_d;
      load_q  <= load_d;
    end
  end

endmodule
